fft_stage_sequencer: RTL
========================

// Module: fft_stage_sequencer
// PURPOSE
//  Sequences the ping-pong complex RAM interface through all log2(N) radix-2 DIT stages of an in-place FFT.
//  - Per stage: issues butterfly read address pairs and twiddle indices.
//  - Replays the same addresses as writes after a fixed datapath latency.
//  - Flips bank_select between stages.
//  Sits between the top-level FFT control and the RAM interface / butterfly pipeline.
// PARAMETERS
//  N        32          FFT size, power of two, >= 4
//  ADDR_W   $clog2(N)   address / pair-index width
//  LAT      4           cycles from rd_en issue to matching wr_en (RAM read latency + butterfly latency), >= 1
// PORTS
//  clk           in   1         clock, all logic on rising edge
//  reset         in   1         asynchronous, active-low reset
//  start         in   1         request a transform; sampled only in IDLE
//  busy          out  1         high from the cycle after start is accepted until done
//  done          out  1         single-cycle pulse, transform complete
//  bank_select   out  1         to RAM interface: 0 = write bank0 / read bank1, 1 = reverse
//  rd_en         out  1         read enable for the current pair
//  rd_address1   out  ADDR_W    butterfly top operand address
//  rd_address2   out  ADDR_W    butterfly bottom operand address
//  wr_en         out  1         write enable, rd_en delayed by LAT
//  wr_address1   out  ADDR_W    rd_address1 delayed by LAT
//  wr_address2   out  ADDR_W    rd_address2 delayed by LAT
//  twiddle_idx   out  ADDR_W-1  W_N exponent for the current pair, aligned with rd_en
//  stage         out  ADDR_W    current stage, 0..log2N-1
//  result_bank   out  1         bank holding the final output; valid while done=1 and in IDLE after it
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, rd_en, wr_en = 0; all addresses, twiddle_idx, stage = 0.
//    bank_select = 1 (input preloaded in bank0). result_bank = 0. LAT-deep delay line cleared.
//  - FSM states: IDLE, READ, DRAIN, SWAP, DONE.
//  - IDLE: start=1 -> READ. On that edge: stage=0, pair j=0, bank_select=1.
//  - READ: rd_en=1 for one pair per cycle, j = 0..N/2-1. After j=N/2-1 -> DRAIN.
//    - Pair address math: half = 1<<stage; pos = j & (half-1); grp = j >> stage.
//    - rd_address1 = (grp << (stage+1)) | pos; rd_address2 = rd_address1 + half.
//    - twiddle_idx = pos << (log2N-1-stage).
//  - DRAIN: rd_en=0 for exactly LAT cycles. The last write of the stage lands in the final DRAIN cycle.
//  - SWAP: one cycle; rd_en=0 and wr_en=0.
//    - If stage < log2N-1: toggle bank_select, stage+1, j=0 -> READ.
//    - Else: bank_select held, result_bank = bank_select -> DONE.
//  - DONE: done=1 for one cycle; busy drops with it; -> IDLE.
//  - Write path: {wr_en, wr_address1, wr_address2} is a plain LAT-stage shift of the read path. No wr_en outside READ/DRAIN.
//  - bank_select is constant from the first rd_en of a stage through its last wr_en.
//    It changes only at the SWAP edge, so the interface's registered bank select settles before the next read.
//  - Timing: stage length = N/2 + LAT + 1 cycles.
//    done asserts log2N*(N/2+LAT+1)+1 cycles after the start-accept edge (N=32, LAT=4: 106).
//  - start while busy or during DONE: ignored, no queuing.
//  - Reset asserted mid-transform: immediate return to reset values. In-flight writes are dropped, not completed.
// CONFIGURATION
//  FFT_SEQ_ABORT_EN defined:
//    - Adds input port abort (1 bit).
//    - abort=1 in READ/DRAIN/SWAP/DONE forces IDLE on the next edge.
//    - Clears the delay line (wr_en=0 from the next cycle); busy=0; done not pulsed; bank_select=1; stage=0.
//    - abort in IDLE has no effect; abort has priority over start in the same cycle.
//  Undefined: no abort port; a transform runs only to completion or reset.
// TESTING
//  1 Reset then idle: hold reset low 3 cycles, release, no start
//    -> all outputs at reset values, bank_select=1, no rd_en/wr_en for 50 cycles.
//  2 N=32, LAT=4, pulse start -> stage 0 pairs (0,1),(2,3)..(30,31) with twiddle_idx 0.
//    - Stage 2, j=5 -> (9,13), twiddle_idx 4.
//    - Stage 4, j=15 -> (15,31), twiddle_idx 15.
//    - done at cycle 106.
//  3 Same run -> each wr_en/address equals rd_en/address 4 cycles earlier.
//    - bank_select sequence 1,0,1,0,1 per stage; result_bank=1; no stage-boundary write with changed bank_select.
//  4 Pulse start again at cycles 10 and 105 of a run -> ignored; exactly one done pulse per accepted start.
//  5 Drop reset at cycle 40 mid-stage -> next cycle rd_en=wr_en=0, busy=0, bank_select=1; a following start runs a full 106-cycle transform.
//  6 FFT_SEQ_ABORT_EN: abort at cycle 30 -> IDLE next cycle, wr_en=0 from then on, no done; with start and abort high together in READ -> abort wins.

Source files
------------

// File: rtl/fft_stage_sequencer_if.sv
// RAM / butterfly-side bus of the FFT stage sequencer: bank select, read pair,
// delayed write pair and twiddle index.
interface fft_stage_sequencer_if #(
  parameter int ADDR_W = 5
);
  logic              bank_select;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_address1;
  logic [ADDR_W-1:0] rd_address2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_address1;
  logic [ADDR_W-1:0] wr_address2;
  logic [ADDR_W-2:0] twiddle_idx;

  modport master (
    output bank_select, rd_en, rd_address1, rd_address2,
           wr_en, wr_address1, wr_address2, twiddle_idx
  );

  modport slave (
    input  bank_select, rd_en, rd_address1, rd_address2,
           wr_en, wr_address1, wr_address2, twiddle_idx
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Walks an in-place radix-2 DIT FFT through all log2(N) stages over a ping-pong RAM.
// Optional abort input enabled by defining FFT_SEQ_ABORT_EN.
module fft_stage_sequencer #(
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N),
  parameter int LAT    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
`ifdef FFT_SEQ_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] stage,
  output logic              result_bank,
  fft_stage_sequencer_if.master ram
);

  localparam int JW = ADDR_W - 1;
  localparam int DW = $clog2(LAT + 1);
  localparam logic [JW-1:0]     J_LAST = JW'(N / 2 - 1);
  localparam logic [ADDR_W-1:0] S_LAST = ADDR_W'(ADDR_W - 1);
  localparam logic [DW-1:0]     D_LAST = DW'(LAT - 1);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, SWAP, DONE} state_t;

  state_t            state_q, state_d;
  logic [JW-1:0]     j_q, j_d;
  logic [ADDR_W-1:0] stage_q, stage_d;
  logic              bank_q, bank_d;
  logic              result_q, result_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic              abort_hit;

`ifdef FFT_SEQ_ABORT_EN
  assign abort_hit = abort && (state_q != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      j_q      <= '0;
      stage_q  <= '0;
      bank_q   <= 1'b1;
      result_q <= 1'b0;
      dcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      j_q      <= j_d;
      stage_q  <= stage_d;
      bank_q   <= bank_d;
      result_q <= result_d;
      dcnt_q   <= dcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    j_d      = j_q;
    stage_d  = stage_q;
    bank_d   = bank_q;
    result_d = result_q;
    dcnt_d   = dcnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          j_d     = '0;
          stage_d = '0;
          bank_d  = 1'b1;
        end
      end
      READ: begin
        j_d = j_q + 1'b1;
        if (j_q == J_LAST) begin
          state_d = DRAIN;
          j_d     = '0;
          dcnt_d  = '0;
        end
      end
      DRAIN: begin
        dcnt_d = dcnt_q + 1'b1;
        if (dcnt_q == D_LAST) state_d = SWAP;
      end
      SWAP: begin
        if (stage_q < S_LAST) begin
          state_d = READ;
          bank_d  = ~bank_q;
          stage_d = stage_q + 1'b1;
          j_d     = '0;
        end else begin
          state_d  = DONE;
          result_d = bank_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_hit) begin
      state_d = IDLE;
      bank_d  = 1'b1;
      stage_d = '0;
      j_d     = '0;
      dcnt_d  = '0;
    end
  end

  // Pair address generation: split j into group/position within the current butterfly span.
  logic [ADDR_W-1:0] j_ext, half, pos, grp, a1, a2;
  logic [JW-1:0]     tw;
  logic              rd_en_c;

  always_comb begin
    j_ext = {1'b0, j_q};
    half  = ADDR_W'(1) << stage_q;
    pos   = j_ext & (half - 1'b1);
    grp   = j_ext >> stage_q;
    a1    = (grp << (stage_q + 1'b1)) | pos;
    a2    = a1 + half;
    tw    = JW'(pos << (S_LAST - stage_q));
  end

  assign rd_en_c         = (state_q == READ);
  assign ram.rd_en       = rd_en_c;
  assign ram.rd_address1 = rd_en_c ? a1 : '0;
  assign ram.rd_address2 = rd_en_c ? a2 : '0;
  assign ram.twiddle_idx = rd_en_c ? tw : '0;
  assign ram.bank_select = bank_q;

  logic [LAT-1:0]    en_sr;
  logic [ADDR_W-1:0] a1_sr [LAT];
  logic [ADDR_W-1:0] a2_sr [LAT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_sr <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        a1_sr[i] <= '0;
        a2_sr[i] <= '0;
      end
    end else if (abort_hit) begin
      en_sr <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        a1_sr[i] <= '0;
        a2_sr[i] <= '0;
      end
    end else begin
      en_sr[0] <= rd_en_c;
      a1_sr[0] <= ram.rd_address1;
      a2_sr[0] <= ram.rd_address2;
      for (int unsigned i = 1; i < LAT; i++) begin
        en_sr[i] <= en_sr[i-1];
        a1_sr[i] <= a1_sr[i-1];
        a2_sr[i] <= a2_sr[i-1];
      end
    end
  end

  assign ram.wr_en       = en_sr[LAT-1];
  assign ram.wr_address1 = a1_sr[LAT-1];
  assign ram.wr_address2 = a2_sr[LAT-1];

  assign busy        = (state_q == READ) || (state_q == DRAIN) || (state_q == SWAP);
  assign done        = (state_q == DONE);
  assign stage       = stage_q;
  assign result_bank = result_q;

endmodule
